i_fetch: RTL and testbench
==========================

I_FETCH -- requirements
Module: i_fetch

Interface
REQ-001 Parameter: RESET_PC, 8'h00, instruction-ROM word address loaded into the fetch PC on reset.
REQ-002 Parameter: DEPTH, 2, prefetch buffer entries; legal values are 2 and 4 only.
REQ-003 Ports: clk  in  1  single clock; all state updates on rising edge.
REQ-004 Ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Ports: fetch_en  in  1  permits new ROM fetches when high.
REQ-006 Ports: rom_addr  out  8  word address to instruction ROM; ROM read is asynchronous.
REQ-007 Ports: rom_data  in  32  instruction word returned combinationally for rom_addr.
REQ-008 Ports: redirect_valid  in  1  branch/jump redirect request, single-cycle pulse.
REQ-009 Ports: redirect_pc  in  8  target word address, qualified by redirect_valid.
REQ-010 Ports: out_valid  out  1  buffer head holds a valid instruction.
REQ-011 Ports: out_ready  in  1  decode stage accepts the head this cycle.
REQ-012 Ports: out_instr  out  32  instruction at buffer head.
REQ-013 Ports: out_pc  out  8  word address of out_instr.

Function
REQ-014 rom_addr shall equal fetch_pc at all times, driven combinationally from the register.
REQ-015 Pop condition: out_valid && out_ready, accepted on the rising edge.
REQ-016 Push condition: state RUN && fetch_en && (count < DEPTH || pop).
- On push, {fetch_pc, rom_data} is written at the tail and fetch_pc increments by 1.
REQ-017 fetch_pc increments mod 256; 8'hFF wraps to 8'h00 with no error indication.
REQ-018 FSM states:
- BOOT: entered on reset; moves to RUN on the first clock edge after rst_n deasserts; no push in BOOT.
- RUN: normal fetch.
- DRAIN: entered from RUN when fetch_en is low; returns to RUN when fetch_en is high.
- In DRAIN, the buffer continues to pop but does not push.
REQ-019 Redirect: when redirect_valid is high, on that edge the buffer is flushed (count=0) and fetch_pc <= redirect_pc.
- The same-cycle push and pop are discarded.
- out_valid is low in the following cycle.
REQ-020 Priority order is reset > redirect > push/pop.
REQ-021 A simultaneous push and pop on a full buffer shall keep count unchanged and preserve FIFO order.
REQ-022 When empty, out_valid shall be 0; out_instr/out_pc are don't-care and shall not be checked.
REQ-023 Latency:
- The first instruction after reset or redirect is presented with out_valid=1 one cycle after the push edge.
- Steady-state throughput is 1 instruction/cycle with out_ready held high.
REQ-024 Counts are DEPTH+1 wide; the buffer never overflows or underflows under any input sequence.

Reset
REQ-025 While rst_n=0, the block shall hold:
- state=BOOT, fetch_pc=RESET_PC, count=0, out_valid=0, out_instr=32'h00000013 (NOP), out_pc=RESET_PC.
- rom_addr=RESET_PC.
REQ-026 Reset asserted mid-operation shall discard all buffered entries and any pending redirect immediately, without waiting for clk.

Configuration
REQ-027 Macro IFETCH_PERF_EN:
- When defined, adds outputs perf_fetched (16 bit, increments per push) and perf_stall (16 bit, increments per cycle with out_valid=1 && out_ready=0).
- Both counters saturate at 16'hFFFF and reset to 0.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Verification
REQ-028 Reset release, fetch_en=1, out_ready=1, ROM preloaded with 0x00200093, 0x00300113, 0x002081b3:
- out_pc 0,1,2 appear on consecutive cycles starting 2 cycles after release, with matching out_instr.
REQ-029 out_ready=0 for 5 cycles with DEPTH=2:
- count saturates at 2; rom_addr holds at head_pc+2.
- After out_ready=1, the sequence resumes with no skipped or duplicated PC.
REQ-030 redirect_valid pulse with redirect_pc=8'h40 while the buffer is full:
- Next cycle out_valid=0; following cycle out_pc=8'h40.
- No pre-redirect PC appears afterward.
REQ-031 fetch_pc at 8'hFE with continuous fetch: out_pc sequence FE, FF, 00, 01.
REQ-032 fetch_en low for 3 cycles with out_ready=1:
- Buffer drains to out_valid=0, rom_addr frozen.
- fetch_en high resumes from the frozen address.
REQ-033 With IFETCH_PERF_EN, 10 pushes and 4 back-pressured valid cycles: perf_fetched=10, perf_stall=4; rst_n pulse mid-run clears both to 0.

Source files
------------

// File: rtl/i_fetch.sv
// i_fetch -- instruction fetch unit with a small prefetch FIFO.
//
// A fetch PC addresses an asynchronous instruction ROM. Each accepted fetch
// pushes {pc, instr} into a DEPTH-entry buffer (DEPTH = 2 or 4). The decode
// stage pops the head with a valid/ready handshake. A redirect flushes the
// buffer and reloads the fetch PC.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   fetch_en              permits new ROM fetches
//   rom_addr / rom_data   ROM word address out, instruction word in
//   redirect_valid/_pc    branch/jump redirect (flush + reload PC)
//   out_valid/_ready      head handshake toward decode
//   out_instr / out_pc    instruction at head and its word address
//
// Optional build macro IFETCH_PERF_EN adds saturating 16-bit counters:
//   perf_fetched (pushes), perf_stall (cycles with out_valid && !out_ready).
module i_fetch #(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter int         DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [7:0]  rom_addr,
  input  logic [31:0] rom_data,
  input  logic        redirect_valid,
  input  logic [7:0]  redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [7:0]  out_pc
`ifdef IFETCH_PERF_EN
  ,
  output logic [15:0] perf_fetched,
  output logic [15:0] perf_stall
`endif
);

  localparam int            PW   = (DEPTH == 4) ? 2 : 1;
  localparam int            CW   = DEPTH + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [31:0]   NOP  = 32'h00000013;

  typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_t;

  typedef struct packed {
    logic [7:0]  pc;
    logic [31:0] instr;
  } entry_t;

  state_t        state;
  logic [7:0]    fetch_pc;
  logic [CW-1:0] count;
  logic [PW-1:0] head, tail;
  entry_t        fifo [DEPTH];
  logic          push, pop;

  assign rom_addr  = fetch_pc;
  assign out_valid = (count != '0);
  assign out_instr = fifo[head].instr;
  assign out_pc    = fifo[head].pc;

  assign pop  = out_valid && out_ready;
  // A full buffer may still accept a fetch when the head leaves this cycle.
  assign push = (state == RUN) && fetch_en && ((count < FULL) || pop);

  // BOOT lasts exactly one edge; afterwards fetch_en alone selects RUN/DRAIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
    end else begin
      case (state)
        BOOT:    state <= RUN;
        default: state <= fetch_en ? RUN : DRAIN;
      endcase
    end
  end

  // Entries reset to NOP/RESET_PC so the head reads sensibly while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
      for (int i = 0; i < DEPTH; i++) fifo[i] <= '{pc: RESET_PC, instr: NOP};
    end else if (redirect_valid) begin
      // Flush: same-cycle push/pop are dropped; pointers collapse onto tail.
      fetch_pc <= redirect_pc;
      count    <= '0;
      head     <= tail;
    end else begin
      if (pop) head <= head + PW'(1);
      if (push) begin
        fifo[tail] <= '{pc: fetch_pc, instr: rom_data};
        tail       <= tail + PW'(1);
        fetch_pc   <= fetch_pc + 8'd1;  // wraps FF -> 00
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

`ifdef IFETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (push && !redirect_valid && (perf_fetched != 16'hFFFF))
        perf_fetched <= perf_fetched + 16'd1;
      if (out_valid && !out_ready && (perf_stall != 16'hFFFF))
        perf_stall <= perf_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_i_fetch.sv
// Testbench for i_fetch: directed scenarios plus randomized traffic, all
// checked against a queue-based reference model of the fetch buffer.
module tb_i_fetch;

  localparam int          DEPTH    = 2;
  localparam logic [7:0]  RESET_PC = 8'h00;
  localparam logic [31:0] NOP      = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic [7:0]  rom_addr;
  logic [31:0] rom_data;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [7:0]  out_pc;
`ifdef IFETCH_PERF_EN
  logic [15:0] perf_fetched, perf_stall;
`endif

  logic [31:0] rom [256];
  assign rom_data = rom[rom_addr];

  always #5 clk = ~clk;

  i_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc)
`ifdef IFETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
  );

  // Reference model: a queue of fetched entries, a fetch pointer and a
  // "running" flag (one boot edge, then running follows fetch_en).
  typedef struct {
    logic [7:0]  pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        mq[$];
  logic [7:0]  mpc;
  bit          booted, running;
  int unsigned mf, ms;
  int          n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mpc = RESET_PC; booted = 0; running = 0; mf = 0; ms = 0;
  endtask

  task automatic model_update();
    bit   pp, ps;
    ent_t e;
    pp = (mq.size() != 0) && out_ready;
    ps = running && fetch_en && ((mq.size() < DEPTH) || pp);
    if ((mq.size() != 0) && !out_ready && ms < 16'hFFFF) ms++;
    if (redirect_valid) begin
      mq.delete();
      mpc = redirect_pc;
    end else begin
      if (pp) void'(mq.pop_front());
      if (ps) begin
        e.pc = mpc; e.instr = rom[mpc];
        mq.push_back(e);
        mpc = mpc + 8'd1;
        if (mf < 16'hFFFF) mf++;
      end
    end
    if (!booted) begin booted = 1; running = 1; end
    else running = fetch_en;
  endtask

  task automatic check_all();
    chk("rom_addr", rom_addr, mpc);
    chk("out_valid", out_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("out_pc", out_pc, mq[0].pc);
      chk("out_instr", out_instr, mq[0].instr);
    end
`ifdef IFETCH_PERF_EN
    chk("perf_fetched", perf_fetched, mf);
    chk("perf_stall", perf_stall, ms);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_all();
  endtask

  // Reset asserted between edges with a redirect pending; must clear at once.
  task automatic async_reset();
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 8'h77;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_addr", rom_addr, RESET_PC);
    chk("arst_pc", out_pc, RESET_PC);
    chk("arst_instr", out_instr, NOP);
`ifdef IFETCH_PERF_EN
    chk("arst_perf_f", perf_fetched, 16'd0);
    chk("arst_perf_s", perf_stall, 16'd0);
`endif
    @(negedge clk);
    redirect_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] prev, frozen;
    bit         seen;
    for (int i = 0; i < 256; i++) rom[i] = $urandom;
    rom[0] = 32'h00200093; rom[1] = 32'h00300113; rom[2] = 32'h002081b3;

    rst_n = 1'b0; fetch_en = 1'b1; out_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 8'h00;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_addr", rom_addr, RESET_PC);
    chk("rst_pc", out_pc, RESET_PC);
    chk("rst_instr", out_instr, NOP);
    rst_n = 1'b1;

    // First instruction two cycles after release, then one per cycle.
    step(); chk("boot_bubble", out_valid, 1'b0);
    step(); chk("pc0", out_pc, 8'h00); chk("i0", out_instr, 32'h00200093);
    step(); chk("pc1", out_pc, 8'h01); chk("i1", out_instr, 32'h00300113);
    step(); chk("pc2", out_pc, 8'h02); chk("i2", out_instr, 32'h002081b3);

    // Back-pressure: buffer fills, fetch address holds two ahead of head.
    out_ready = 1'b0;
    repeat (5) step();
    chk("bp_hold_addr", rom_addr, out_pc + 8'd2);
    out_ready = 1'b1;
    prev = out_pc;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_resume_seq", out_pc, prev + 8'd1);
      prev = out_pc;
    end

    // Redirect while full.
    out_ready = 1'b0;
    repeat (3) step();
    redirect_valid = 1'b1; redirect_pc = 8'h40;
    step();
    redirect_valid = 1'b0; out_ready = 1'b1;
    chk("redir_bubble", out_valid, 1'b0);
    step(); chk("redir_valid", out_valid, 1'b1); chk("redir_pc", out_pc, 8'h40);
    step(); chk("redir_next", out_pc, 8'h41);

    // PC wrap.
    redirect_valid = 1'b1; redirect_pc = 8'hFE;
    step();
    redirect_valid = 1'b0;
    step(); chk("wrap_fe", out_pc, 8'hFE);
    step(); chk("wrap_ff", out_pc, 8'hFF);
    step(); chk("wrap_00", out_pc, 8'h00);
    step(); chk("wrap_01", out_pc, 8'h01);

    // Drain with fetch disabled, then resume from the frozen address.
    fetch_en = 1'b0;
    frozen = rom_addr;
    repeat (3) begin
      step();
      chk("drain_frozen", rom_addr, frozen);
    end
    chk("drain_empty", out_valid, 1'b0);
    fetch_en = 1'b1;
    seen = 0;
    for (int i = 0; i < 4 && !seen; i++) begin
      step();
      if (out_valid) seen = 1;
    end
    chk("resume_seen", seen, 1'b1);
    chk("resume_pc", out_pc, frozen);

    // Randomized traffic with one asynchronous reset in the middle.
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) async_reset();
      fetch_en       = ($urandom_range(0, 9) != 0);
      out_ready      = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = 8'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
